// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory unit between the eval unit (client 0) and
// the host loader/REPL (client 1). Each client sees a private-memory style
// execute/ready handshake; requests are buffered, issued one at a time with
// round-robin priority, and each response is routed back to its requester.

module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_execute,
    input  logic [1:0]        c0_func,
    input  logic [ADDR_W-1:0] c0_addr0,
    input  logic [ADDR_W-1:0] c0_addr1,
    input  logic [3:0]        c0_type_info,
    output logic              c0_ready,
    output logic [ADDR_W-1:0] c0_addr,
    output logic [DATA_W-1:0] c0_data,
    input  logic              c1_execute,
    input  logic [1:0]        c1_func,
    input  logic [ADDR_W-1:0] c1_addr0,
    input  logic [ADDR_W-1:0] c1_addr1,
    input  logic [3:0]        c1_type_info,
    output logic              c1_ready,
    output logic [ADDR_W-1:0] c1_addr,
    output logic [DATA_W-1:0] c1_data,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [3:0]        mem_type_info,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              grant,
    output logic              busy,
    output logic [1:0]        overflow
);

    localparam logic [1:0] POWERUP = 2'd0;
    localparam logic [1:0] IDLE    = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;

    logic [1:0]        state;
    logic [1:0]        pend;
    logic              last_grant;
    logic              sel;
    logic [1:0]        exec;
    logic [1:0]        done;

    logic [1:0]        in_func      [2];
    logic [ADDR_W-1:0] in_addr0     [2];
    logic [ADDR_W-1:0] in_addr1     [2];
    logic [3:0]        in_type_info [2];

    logic [1:0]        buf_func      [2];
    logic [ADDR_W-1:0] buf_addr0     [2];
    logic [ADDR_W-1:0] buf_addr1     [2];
    logic [3:0]        buf_type_info [2];

    assign exec            = {c1_execute, c0_execute};
    assign in_func[0]      = c0_func;
    assign in_func[1]      = c1_func;
    assign in_addr0[0]     = c0_addr0;
    assign in_addr0[1]     = c1_addr0;
    assign in_addr1[0]     = c0_addr1;
    assign in_addr1[1]     = c1_addr1;
    assign in_type_info[0] = c0_type_info;
    assign in_type_info[1] = c1_type_info;

    // Completion of the granted client's transaction happens on this edge
    assign done[0] = (state == WAIT) && mem_ready && !grant;
    assign done[1] = (state == WAIT) && mem_ready && grant;

    // On a tie the client that was not served last wins; otherwise the lone pending one
    assign sel = (&pend) ? ~last_grant : pend[1];

    // Latch each client's pulsed request and flag requests that arrive while one is still outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= 2'b00;
            overflow <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                buf_func[n]      <= '0;
                buf_addr0[n]     <= '0;
                buf_addr1[n]     <= '0;
                buf_type_info[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (exec[n]) begin
                    if (pend[n] && !done[n]) begin
                        overflow[n] <= 1'b1;
                    end else begin
                        pend[n]          <= 1'b1;
                        buf_func[n]      <= in_func[n];
                        buf_addr0[n]     <= in_addr0[n];
                        buf_addr1[n]     <= in_addr1[n];
                        buf_type_info[n] <= in_type_info[n];
                    end
                end else if (done[n]) begin
                    pend[n] <= 1'b0;
                end
            end
        end
    end

    // Sequence power-up, issue and completion, registering every outgoing signal
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= POWERUP;
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            busy          <= 1'b0;
            mem_execute   <= 1'b0;
            mem_func      <= '0;
            mem_addr0     <= '0;
            mem_addr1     <= '0;
            mem_type_info <= '0;
            c0_ready      <= 1'b0;
            c0_addr       <= '0;
            c0_data       <= '0;
            c1_ready      <= 1'b0;
            c1_addr       <= '0;
            c1_data       <= '0;
        end else begin
            mem_execute   <= 1'b0;
            mem_func      <= '0;
            mem_addr0     <= '0;
            mem_addr1     <= '0;
            mem_type_info <= '0;
            c0_ready      <= 1'b0;
            c1_ready      <= 1'b0;
            case (state)
                POWERUP: begin
                    if (mem_ready) begin
                        c0_ready <= 1'b1;
                        c0_addr  <= '0;
                        c0_data  <= '0;
                        c1_ready <= 1'b1;
                        c1_addr  <= '0;
                        c1_data  <= '0;
                        state    <= IDLE;
                    end
                end
                IDLE: begin
                    if (|pend) begin
                        mem_execute   <= 1'b1;
                        mem_func      <= buf_func[sel];
                        mem_addr0     <= buf_addr0[sel];
                        mem_addr1     <= buf_addr1[sel];
                        mem_type_info <= buf_type_info[sel];
                        grant         <= sel;
                        busy          <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (grant) begin
                            c1_ready <= 1'b1;
                            c1_addr  <= mem_addr;
                            c1_data  <= mem_data;
                        end else begin
                            c0_ready <= 1'b1;
                            c0_addr  <= mem_addr;
                            c0_data  <= mem_data;
                        end
                        last_grant <= grant;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for the two-client memory arbiter with
// hand-computed expectations and a simple hand-driven memory responder.

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c0_execute = 1'b0;
    logic [1:0]  c0_func = '0;
    logic [9:0]  c0_addr0 = '0;
    logic [9:0]  c0_addr1 = '0;
    logic [3:0]  c0_type_info = '0;
    logic        c0_ready;
    logic [9:0]  c0_addr;
    logic [23:0] c0_data;
    logic        c1_execute = 1'b0;
    logic [1:0]  c1_func = '0;
    logic [9:0]  c1_addr0 = '0;
    logic [9:0]  c1_addr1 = '0;
    logic [3:0]  c1_type_info = '0;
    logic        c1_ready;
    logic [9:0]  c1_addr;
    logic [23:0] c1_data;
    logic        mem_execute;
    logic [1:0]  mem_func;
    logic [9:0]  mem_addr0;
    logic [9:0]  mem_addr1;
    logic [3:0]  mem_type_info;
    logic        mem_ready = 1'b0;
    logic [9:0]  mem_addr = '0;
    logic [23:0] mem_data = '0;
    logic        grant;
    logic        busy;
    logic [1:0]  overflow;

    int tests_run = 0;
    int tests_failed = 0;

    mem_arbiter #(.ADDR_W(10), .DATA_W(24)) dut (
        .clk(clk), .rst(rst),
        .c0_execute(c0_execute), .c0_func(c0_func), .c0_addr0(c0_addr0), .c0_addr1(c0_addr1),
        .c0_type_info(c0_type_info), .c0_ready(c0_ready), .c0_addr(c0_addr), .c0_data(c0_data),
        .c1_execute(c1_execute), .c1_func(c1_func), .c1_addr0(c1_addr0), .c1_addr1(c1_addr1),
        .c1_type_info(c1_type_info), .c1_ready(c1_ready), .c1_addr(c1_addr), .c1_data(c1_data),
        .mem_execute(mem_execute), .mem_func(mem_func), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
        .mem_type_info(mem_type_info), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .grant(grant), .busy(busy), .overflow(overflow)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Advance past the next rising edge so outputs are sampled away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a memory response after a number of idle cycles, then sample past its edge
    task automatic mem_respond(input int delay, input logic [9:0] a, input logic [23:0] d);
        repeat (delay) tick();
        mem_ready = 1'b1;
        mem_addr  = a;
        mem_data  = d;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        tests_run++; if (mem_execute !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_execute: got %b expected 0", mem_execute); end
        tests_run++; if ({c0_ready, c1_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 00", {c0_ready, c1_ready}); end
        tests_run++; if ({busy, grant, overflow} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_status: got %b expected 0000", {busy, grant, overflow}); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_powerup();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (mem_execute !== 1'b0 || c0_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL powerup_hold: got exec=%b rdy0=%b expected 0 0", mem_execute, c0_ready); end
        end
        mem_respond(0, 10'h3ff, 24'hffffff);
        tests_run++; if ({c0_ready, c1_ready} !== 2'b11) begin tests_failed++; $display("[TB] FAIL powerup_ready: got %b expected 11", {c0_ready, c1_ready}); end
        tests_run++; if (c0_data !== 24'h0 || c1_data !== 24'h0 || c0_addr !== 10'h0) begin tests_failed++; $display("[TB] FAIL powerup_data: got %h %h %h expected 0 0 0", c0_data, c1_data, c0_addr); end
        tick();
        tests_run++; if ({c0_ready, c1_ready, mem_execute} !== 3'b000) begin tests_failed++; $display("[TB] FAIL powerup_pulse_end: got %b expected 000", {c0_ready, c1_ready, mem_execute}); end
    endtask

    task automatic test_simultaneous();
        c0_execute = 1'b1; c0_func = 2'd0; c0_addr0 = 10'd5;
        c1_execute = 1'b1; c1_func = 2'd0; c1_addr0 = 10'd9;
        tick();
        c0_execute = 1'b0; c1_execute = 1'b0;
        tests_run++; if (mem_execute !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_latency: got %b expected 0", mem_execute); end
        tick();
        tests_run++; if ({mem_execute, mem_addr0, grant, busy} !== {1'b1, 10'd5, 1'b0, 1'b1}) begin tests_failed++; $display("[TB] FAIL tie_first: got exec=%b a0=%0d g=%b b=%b expected 1 5 0 1", mem_execute, mem_addr0, grant, busy); end
        tick();
        tests_run++; if (mem_execute !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_pulse_width: got %b expected 0", mem_execute); end
        // Client 0 re-requests on the very edge it completes: both pending again, client 1 must win
        mem_ready = 1'b1; mem_addr = 10'h011; mem_data = 24'h000aaa;
        c0_execute = 1'b1; c0_addr0 = 10'd6;
        tick();
        mem_ready = 1'b0; c0_execute = 1'b0;
        tests_run++; if ({c0_ready, c1_ready} !== 2'b10 || c0_data !== 24'h000aaa) begin tests_failed++; $display("[TB] FAIL tie_resp0: got rdy=%b d=%h expected 10 000aaa", {c0_ready, c1_ready}, c0_data); end
        tick();
        tests_run++; if ({mem_execute, mem_addr0, grant} !== {1'b1, 10'd9, 1'b1}) begin tests_failed++; $display("[TB] FAIL tie_second: got exec=%b a0=%0d g=%b expected 1 9 1", mem_execute, mem_addr0, grant); end
        tests_run++; if (overflow !== 2'b00) begin tests_failed++; $display("[TB] FAIL tie_no_overflow: got %b expected 00", overflow); end
        mem_respond(1, 10'h022, 24'h000bbb);
        tests_run++; if ({c0_ready, c1_ready} !== 2'b01 || c1_data !== 24'h000bbb || c0_data !== 24'h000aaa) begin tests_failed++; $display("[TB] FAIL tie_resp1: got rdy=%b d1=%h d0=%h expected 01 000bbb 000aaa", {c0_ready, c1_ready}, c1_data, c0_data); end
        tick();
        tests_run++; if ({mem_execute, mem_addr0, grant} !== {1'b1, 10'd6, 1'b0}) begin tests_failed++; $display("[TB] FAIL tie_recaptured: got exec=%b a0=%0d g=%b expected 1 6 0", mem_execute, mem_addr0, grant); end
        mem_respond(0, 10'h033, 24'h000ccc);
        tests_run++; if (c0_ready !== 1'b1 || c0_data !== 24'h000ccc) begin tests_failed++; $display("[TB] FAIL tie_resp0b: got rdy=%b d=%h expected 1 000ccc", c0_ready, c0_data); end
        tick();
    endtask

    task automatic test_single();
        c0_execute = 1'b1; c0_func = 2'd0; c0_addr0 = 10'h001; c0_addr1 = 10'h000; c0_type_info = 4'd0;
        tick();
        c0_execute = 1'b0;
        tick();
        tests_run++; if ({mem_execute, mem_func, mem_addr0, grant} !== {1'b1, 2'd0, 10'h001, 1'b0}) begin tests_failed++; $display("[TB] FAIL single_issue: got exec=%b f=%0d a0=%h g=%b expected 1 0 001 0", mem_execute, mem_func, mem_addr0, grant); end
        mem_respond(3, 10'h001, 24'h300005);
        tests_run++; if ({c0_ready, c1_ready} !== 2'b10 || c0_data !== 24'h300005 || c0_addr !== 10'h001) begin tests_failed++; $display("[TB] FAIL single_resp: got rdy=%b d=%h a=%h expected 10 300005 001", {c0_ready, c1_ready}, c0_data, c0_addr); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_busy: got %b expected 0", busy); end
        tick();
        tests_run++; if (c0_ready !== 1'b0 || c0_data !== 24'h300005 || mem_execute !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_hold: got rdy=%b d=%h exec=%b expected 0 300005 0", c0_ready, c0_data, mem_execute); end
    endtask

    task automatic test_busy();
        c0_execute = 1'b1; c0_func = 2'd0; c0_addr0 = 10'd2;
        tick();
        c0_execute = 1'b0;
        tick();
        c1_execute = 1'b1; c1_func = 2'd1; c1_addr0 = 10'd3; c1_addr1 = 10'd7; c1_type_info = 4'd5;
        tick();
        c1_execute = 1'b0;
        tests_run++; if (mem_execute !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_no_issue: got exec=%b busy=%b expected 0 1", mem_execute, busy); end
        mem_respond(1, 10'h044, 24'h000111);
        tests_run++; if ({c0_ready, c1_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL busy_resp0: got %b expected 10", {c0_ready, c1_ready}); end
        tick();
        tests_run++; if ({mem_execute, mem_func, mem_addr0, mem_addr1, mem_type_info, grant} !== {1'b1, 2'd1, 10'd3, 10'd7, 4'd5, 1'b1}) begin tests_failed++; $display("[TB] FAIL busy_issue1: got exec=%b f=%0d a0=%0d a1=%0d t=%0d g=%b expected 1 1 3 7 5 1", mem_execute, mem_func, mem_addr0, mem_addr1, mem_type_info, grant); end
        mem_respond(2, 10'h155, 24'h500155);
        tests_run++; if ({c0_ready, c1_ready} !== 2'b01 || c1_addr !== 10'h155 || c1_data !== 24'h500155) begin tests_failed++; $display("[TB] FAIL busy_resp1: got rdy=%b a=%h d=%h expected 01 155 500155", {c0_ready, c1_ready}, c1_addr, c1_data); end
        tick();
    endtask

    task automatic test_overflow();
        c0_execute = 1'b1; c0_addr0 = 10'd4;
        tick();
        c0_execute = 1'b0;
        tick();
        tests_run++; if (mem_execute !== 1'b1 || mem_addr0 !== 10'd4) begin tests_failed++; $display("[TB] FAIL ovf_issue: got exec=%b a0=%0d expected 1 4", mem_execute, mem_addr0); end
        c0_execute = 1'b1; c0_addr0 = 10'd8;
        tick();
        c0_execute = 1'b0;
        tests_run++; if (overflow !== 2'b01) begin tests_failed++; $display("[TB] FAIL ovf_flag: got %b expected 01", overflow); end
        mem_respond(1, 10'h004, 24'h000444);
        tests_run++; if (c0_ready !== 1'b1 || c0_data !== 24'h000444) begin tests_failed++; $display("[TB] FAIL ovf_resp: got rdy=%b d=%h expected 1 000444", c0_ready, c0_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (mem_execute !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_dropped: got exec=%b busy=%b expected 0 0", mem_execute, busy); end
        end
        tests_run++; if (overflow !== 2'b01) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got %b expected 01", overflow); end
    endtask

    task automatic test_reset_midop();
        c1_execute = 1'b1; c1_addr0 = 10'd1;
        tick();
        c1_execute = 1'b0;
        tick();
        tests_run++; if (mem_execute !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL midop_issue: got exec=%b busy=%b expected 1 1", mem_execute, busy); end
        #2;
        rst = 1'b0;
        #1;
        tests_run++; if ({mem_execute, busy, grant, overflow, c0_ready, c1_ready} !== 7'b0) begin tests_failed++; $display("[TB] FAIL midop_clear: got %b expected 0000000", {mem_execute, busy, grant, overflow, c0_ready, c1_ready}); end
        tests_run++; if (c1_data !== 24'h0 || c0_data !== 24'h0 || mem_addr0 !== 10'h0) begin tests_failed++; $display("[TB] FAIL midop_data: got %h %h %h expected 0 0 0", c1_data, c0_data, mem_addr0); end
        #1;
        rst = 1'b1;
        mem_respond(1, 10'h2aa, 24'habcdef);
        tests_run++; if ({c0_ready, c1_ready} !== 2'b11 || c1_data !== 24'h0 || c1_addr !== 10'h0) begin tests_failed++; $display("[TB] FAIL midop_powerup: got rdy=%b d1=%h a1=%h expected 11 0 0", {c0_ready, c1_ready}, c1_data, c1_addr); end
        tick();
        tests_run++; if (mem_execute !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midop_abandoned: got exec=%b busy=%b expected 0 0", mem_execute, busy); end
    endtask

    // Run every scenario in order and report
    initial begin
        test_reset();
        test_powerup();
        test_simultaneous();
        test_single();
        test_busy();
        test_overflow();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter sharing the single memory unit between the eval unit (client 0) and the host loader/REPL front end (client 1). Each client sees an interface identical to a private memory unit: a one-cycle execute pulse, then it waits for a one-cycle ready pulse carrying the address and data results. The arbiter latches each pulsed request, serialises requests to the memory unit with round-robin priority, and routes each response back to its requester. It also forwards the memory power-up ready to both clients.

Parameters:
ADDR_W, 10, cell address width (matches `memory_addr_width)
DATA_W, 24, cell data width (matches `memory_data_width)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
c0_execute  input  1  client 0 request pulse (one cycle)
c0_func  input  2  client 0 memory function (`GET_CONTENTS, `GET_CONS, ...)
c0_addr0, c0_addr1  input  ADDR_W  client 0 operand addresses
c0_type_info  input  4  client 0 cell type for cons
c0_ready  output  1  client 0 response pulse
c0_addr  output  ADDR_W  client 0 returned address
c0_data  output  DATA_W  client 0 returned data
c1_execute, c1_func, c1_addr0, c1_addr1, c1_type_info, c1_ready, c1_addr, c1_data  same as c0_*, for client 1
mem_execute  output  1  request pulse to memory unit
mem_func  output  2  function to memory unit
mem_addr0, mem_addr1  output  ADDR_W  operands to memory unit
mem_type_info  output  4  type to memory unit
mem_ready  input  1  memory done pulse (first pulse after reset = powered up)
mem_addr  input  ADDR_W  memory returned address
mem_data  input  DATA_W  memory returned data
grant  output  1  client currently owning memory (valid while busy)
busy  output  1  transaction outstanding
overflow  output  2  sticky per-client error: execute while already pending

Behaviour:
- Reset: all outputs 0, pending[1:0]=0, last_grant=1 (client 0 wins the first tie), state=POWERUP. Reset mid-transaction abandons it; no response is delivered.
- All outputs are registered.
- Capture: cN_execute=1 at an edge -> pendN<=1 and the request fields are latched into a per-client buffer. If pendN is already 1 and the request is not completing that edge: overflow[N]<=1 and the new request is dropped.
- If execute arrives on the same edge as that client's completion, the new request is captured and pending stays 1.
- POWERUP: mem_* held 0; requests are captured but not issued. On mem_ready=1: c0_ready and c1_ready pulse for 1 cycle with addr/data=0 -> IDLE.
- IDLE: if any pendN=1, select a client.
  - Both pending: pick the client != last_grant. Otherwise pick the one pending.
  - Drive mem_* from the selected buffer with mem_execute=1 for exactly one cycle. grant<=sel, busy<=1 -> WAIT.
- WAIT: mem_execute, mem_func, mem_addr0/1, mem_type_info driven 0. On mem_ready=1:
  - c[grant]_ready<=1 for one cycle; c[grant]_addr<=mem_addr; c[grant]_data<=mem_data.
  - pend[grant]<=0 (unless re-captured this edge); last_grant<=grant; busy<=0 -> IDLE.
- c*_addr and c*_data hold their last value between pulses. The non-granted client's ready never pulses.
- mem_ready in IDLE is ignored.
- Latency: execute sampled at edge k -> mem_execute high after edge k+1 (if idle). mem_ready sampled at edge j -> cN_ready high after edge j. Back-to-back issue: the next mem_execute goes high one cycle after the ready edge (IDLE cycle).
- No timeout; WAIT persists until mem_ready.
- State encoding: POWERUP=0, IDLE=1, WAIT=2. Unreachable encodings go to IDLE.

Test Plan:
- Power-up: reset, hold mem_ready=0 for 5 cycles, then pulse once -> c0_ready and c1_ready each pulse 1 cycle with data 0. No mem_execute during POWERUP.
- Single request: c0 pulses GET_CONTENTS, addr0=10'h001 -> mem_execute 1 cycle later with mem_addr0=1. Model returns data 24'h3_00005 after 3 cycles -> c0_ready=1, c0_data=24'h300005 next cycle; c1_ready stays 0.
- Simultaneous: c0 and c1 pulse on the same edge (addr0 5 and 9) -> client 0 is served first (mem_addr0=5), then client 1 (mem_addr0=9). A repeated tie after that serves client 1 first.
- Request while busy: c1 pulses GET_CONS (addr0=3, addr1=7, type 5) during c0's WAIT -> issued in the cycle after c0's completion with mem_type_info=5; c1_addr=the memory's returned address.
- Overflow: c0 pulses twice before completion -> overflow=2'b01 sticky; only one mem_execute for client 0.
- Reset mid-op: assert rst during WAIT -> all outputs 0 immediately, state POWERUP; a subsequent mem_ready is treated as power-up, not as a client response.
